// File: rtl/bus_timer_if.sv
// CPU data-bus port of the machine timer.
// The CPU drives the request side; the timer answers.
interface bus_timer_if;
  logic [31:0] address;
  logic        rw_req;
  logic        rw;
  logic [31:0] write_data;
  logic [1:0]  size;
  logic [31:0] read_data;
  logic        data_valid;
  logic        irq;

  modport master (
    output address, rw_req, rw, write_data, size,
    input  read_data, data_valid, irq
  );

  modport slave (
    input  address, rw_req, rw, write_data, size,
    output read_data, data_valid, irq
  );
endinterface

// File: rtl/bus_timer.sv
// Memory-mapped 64-bit machine timer with compare interrupt.
// One access per request; ACK holds until rw_req drops.
module bus_timer #(
  parameter logic [31:0] BASE           = 32'h8000_1000,
  parameter logic [15:0] RESET_PRESCALE = 16'd0
) (
  input logic        clk,
  input logic        reset,
  bus_timer_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE,
    ACK
  } state_t;

  state_t      state;
  state_t      next;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        enable;
  logic [15:0] prescale;
  logic [15:0] pcount;
  logic [31:0] shadow;
  logic [31:0] rdata;
  logic        valid;
  logic        irq;

  logic        hit;
  logic        access;
  logic        wr;
  logic        rd;
  logic        tick;
  logic [5:0]  word;
  logic        sel_mlo;
  logic        sel_mhi;
  logic        sel_clo;
  logic        sel_chi;
  logic        sel_ctrl;
  logic        sel_pre;
  logic [3:0]  be;
  logic [31:0] live;
  logic [31:0] merged;

  assign hit    = bus.address[31:8] == BASE[31:8];
  assign access = (state == IDLE) && bus.rw_req && hit;
  assign wr     = access && bus.rw;
  assign rd     = access && !bus.rw;
  assign tick   = enable && (pcount == prescale);

  assign word     = bus.address[7:2];
  assign sel_mlo  = word == 6'h0;
  assign sel_mhi  = word == 6'h1;
  assign sel_clo  = word == 6'h2;
  assign sel_chi  = word == 6'h3;
  assign sel_ctrl = word == 6'h4;
  assign sel_pre  = word == 6'h5;

  always_comb begin
    be = 4'b1111;
    unique case (bus.size)
      2'd0:    be = 4'b0001 << bus.address[1:0];
      2'd1:    be = bus.address[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Live register value; MTIME_HI reads use the shadow instead.
  always_comb begin
    live = '0;
    unique case (1'b1)
      sel_mlo:  live = mtime[31:0];
      sel_mhi:  live = mtime[63:32];
      sel_clo:  live = mtimecmp[31:0];
      sel_chi:  live = mtimecmp[63:32];
      sel_ctrl: live = {31'b0, enable};
      sel_pre:  live = {16'b0, prescale};
      default:  live = '0;
    endcase
  end

  always_comb begin
    merged = live;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = bus.write_data[8*i +: 8];
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE: if (access) next = ACK;
      ACK:  if (!bus.rw_req) next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      valid    <= 1'b0;
      irq      <= 1'b0;
      rdata    <= '0;
      mtime    <= '0;
      mtimecmp <= '1;
      enable   <= 1'b0;
      prescale <= RESET_PRESCALE;
      pcount   <= '0;
      shadow   <= '0;
    end else begin
      state <= next;
      valid <= next == ACK;
      irq   <= enable && (mtime >= mtimecmp);

      if (enable) begin
        pcount <= tick ? 16'd0 : pcount + 16'd1;
        if (tick) mtime <= mtime + 64'd1;
      end

      if (rd) begin
        rdata <= sel_mhi ? shadow : live;
        if (sel_mlo) shadow <= mtime[63:32];
      end

      // A CPU write overrides this cycle's increment entirely.
      if (wr) begin
        unique case (1'b1)
          sel_mlo: mtime <= {mtime[63:32], merged};
          sel_mhi: mtime <= {merged, mtime[31:0]};
          sel_clo: mtimecmp[31:0] <= merged;
          sel_chi: mtimecmp[63:32] <= merged;
          sel_ctrl: begin
            enable <= merged[0];
            pcount <= '0;
          end
          sel_pre: begin
            prescale <= merged[15:0];
            pcount   <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.read_data  = rdata;
  assign bus.data_valid = valid;
  assign bus.irq        = irq;

endmodule

// File: tb/tb_bus_timer.sv
// Bench for bus_timer: vector table, directed corners,
// random accesses against a cycle-level reference model.
module tb_bus_timer;

  localparam logic [31:0] BASE = 32'h8000_1000;

  logic clk = 1'b0;
  logic reset = 1'b1;

  bus_timer_if bus ();

  bus_timer #(
    .BASE           (BASE),
    .RESET_PRESCALE (16'd0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference state
  logic [63:0] m_time;
  logic [63:0] m_cmp;
  logic        m_en;
  logic [15:0] m_pre;
  longint      m_phase;
  logic [31:0] m_shadow;
  logic [31:0] m_rd;
  logic        m_busy;
  logic        m_irq;

  typedef struct {
    logic [7:0]  off;
    logic        rw;
    logic [1:0]  size;
    logic [31:0] wdata;
    int          hold;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_live(input logic [5:0] w);
    case (w)
      6'd0:    return m_time[31:0];
      6'd1:    return m_time[63:32];
      6'd2:    return m_cmp[31:0];
      6'd3:    return m_cmp[63:32];
      6'd4:    return {31'b0, m_en};
      6'd5:    return {16'b0, m_pre};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_lanes(input logic [31:0] old,
                                          input logic [31:0] wd,
                                          input logic [1:0]  a,
                                          input logic [1:0]  sz);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      bit take;
      if (sz == 2'd0)      take = (i == int'(a));
      else if (sz == 2'd1) take = ((i / 2) == int'(a[1]));
      else                 take = 1'b1;
      if (take) r[8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction

  task automatic model_edge();
    logic        acc;
    logic        tick;
    logic [63:0] nt;
    logic [31:0] nv;
    logic [5:0]  w;
    if (reset) begin
      m_time   = '0;
      m_cmp    = '1;
      m_en     = 1'b0;
      m_pre    = 16'd0;
      m_phase  = 0;
      m_shadow = '0;
      m_rd     = '0;
      m_busy   = 1'b0;
      m_irq    = 1'b0;
    end else begin
      w   = bus.address[7:2];
      acc = !m_busy && bus.rw_req &&
            (bus.address[31:8] == BASE[31:8]);
      m_irq = m_en && (m_time >= m_cmp);
      // mtime advances once every (PRESCALE+1) enabled cycles
      tick = m_en &&
             ((m_phase + 1) % (longint'(m_pre) + 1) == 0);
      nt = m_time + (tick ? 64'd1 : 64'd0);
      if (m_en) m_phase++;
      if (acc && bus.rw) begin
        nv = m_lanes(m_live(w), bus.write_data,
                     bus.address[1:0], bus.size);
        case (w)
          6'd0: nt = {m_time[63:32], nv};
          6'd1: nt = {nv, m_time[31:0]};
          6'd2: m_cmp[31:0] = nv;
          6'd3: m_cmp[63:32] = nv;
          6'd4: begin
            m_en    = nv[0];
            m_phase = 0;
          end
          6'd5: begin
            m_pre   = nv[15:0];
            m_phase = 0;
          end
          default: ;
        endcase
      end
      if (acc && !bus.rw) begin
        m_rd = (w == 6'd1) ? m_shadow : m_live(w);
        if (w == 6'd0) m_shadow = m_time[63:32];
      end
      m_time = nt;
      m_busy = acc || (m_busy && bus.rw_req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("data_valid", {31'b0, bus.data_valid}, {31'b0, m_busy});
    chk("irq", {31'b0, bus.irq}, {31'b0, m_irq});
    chk("read_data", bus.read_data, m_rd);
  endtask

  task automatic access(input logic [7:0]  off,
                        input logic        rw,
                        input logic [1:0]  sz,
                        input logic [31:0] wd,
                        input int          hold,
                        output logic [31:0] rd);
    bus.address    = BASE + {24'b0, off};
    bus.rw         = rw;
    bus.size       = sz;
    bus.write_data = wd;
    bus.rw_req     = 1'b1;
    step();
    chk("latency", {31'b0, bus.data_valid}, 32'd1);
    repeat (hold) step();
    rd = bus.read_data;
    bus.rw_req = 1'b0;
    step();
    chk("dv_fall", {31'b0, bus.data_valid}, 32'd0);
  endtask

  task automatic wr32(input logic [7:0] off,
                      input logic [31:0] wd);
    logic [31:0] rd;
    access(off, 1'b1, 2'd2, wd, 0, rd);
  endtask

  task automatic rd32(input logic [7:0] off,
                      output logic [31:0] rd);
    access(off, 1'b0, 2'd2, 32'h0, 0, rd);
  endtask

  task automatic outside(input logic [31:0] addr,
                         input int cycles);
    bus.address = addr;
    bus.rw      = 1'b1;
    bus.size    = 2'd2;
    bus.rw_req  = 1'b1;
    repeat (cycles) step();
    chk("outside_dv", {31'b0, bus.data_valid}, 32'd0);
    bus.rw_req = 1'b0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: no finish got 0 expected 1");
    $fatal(1);
  end

  initial begin
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] r3;
    int n;

    tbl[0]  = '{8'h00, 1'b0, 2'd2, 32'h0, 3, 1'b1, 32'h0};
    tbl[1]  = '{8'h04, 1'b0, 2'd2, 32'h0, 0, 1'b1, 32'h0};
    tbl[2]  = '{8'h08, 1'b0, 2'd2, 32'h0, 0, 1'b1, 32'hFFFF_FFFF};
    tbl[3]  = '{8'h0C, 1'b0, 2'd2, 32'h0, 0, 1'b1, 32'hFFFF_FFFF};
    tbl[4]  = '{8'h10, 1'b0, 2'd2, 32'h0, 0, 1'b1, 32'h0};
    tbl[5]  = '{8'h14, 1'b0, 2'd2, 32'h0, 0, 1'b1, 32'h0};
    tbl[6]  = '{8'h09, 1'b1, 2'd0, 32'h0000_AB00, 0, 1'b0, 32'h0};
    tbl[7]  = '{8'h0E, 1'b1, 2'd1, 32'hBEEF_0000, 0, 1'b0, 32'h0};
    tbl[8]  = '{8'h08, 1'b0, 2'd0, 32'h0, 0, 1'b1, 32'hFFFF_ABFF};
    tbl[9]  = '{8'h0C, 1'b0, 2'd1, 32'h0, 0, 1'b1, 32'hBEEF_FFFF};
    tbl[10] = '{8'h40, 1'b0, 2'd2, 32'h0, 0, 1'b1, 32'h0};
    tbl[11] = '{8'h40, 1'b1, 2'd2, 32'hDEAD_BEEF, 0, 1'b0, 32'h0};
    tbl[12] = '{8'h14, 1'b1, 2'd2, 32'h0001_2345, 4, 1'b0, 32'h0};
    tbl[13] = '{8'h14, 1'b0, 2'd2, 32'h0, 0, 1'b1, 32'h0000_2345};
    tbl[14] = '{8'h10, 1'b1, 2'd2, 32'hFFFF_FFFE, 0, 1'b0, 32'h0};
    tbl[15] = '{8'h10, 1'b0, 2'd2, 32'h0, 0, 1'b1, 32'h0};
    tbl[16] = '{8'h16, 1'b1, 2'd1, 32'h00AA_0000, 0, 1'b0, 32'h0};
    tbl[17] = '{8'h14, 1'b0, 2'd2, 32'h0, 0, 1'b1, 32'h0000_2345};
    tbl[18] = '{8'h0A, 1'b1, 2'd3, 32'h1234_5678, 0, 1'b0, 32'h0};
    tbl[19] = '{8'h08, 1'b0, 2'd2, 32'h0, 0, 1'b1, 32'h1234_5678};

    bus.address    = '0;
    bus.rw_req     = 1'b0;
    bus.rw         = 1'b0;
    bus.write_data = '0;
    bus.size       = 2'd2;
    reset          = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();

    for (int i = 0; i < 20; i++) begin
      access(tbl[i].off, tbl[i].rw, tbl[i].size,
             tbl[i].wdata, tbl[i].hold, r1);
      if (tbl[i].chk) chk($sformatf("tbl%0d", i), r1, tbl[i].exp);
    end

    // prescale 3: about one tick per four cycles
    wr32(8'h14, 32'd3);
    wr32(8'h10, 32'd1);
    repeat (40) step();
    rd32(8'h00, r1);
    chk("presc3_mtime", {31'b0, (r1 >= 9 && r1 <= 11)}, 32'd1);

    wr32(8'h14, 32'd0);
    rd32(8'h00, r1);
    repeat (10) step();
    rd32(8'h00, r2);
    chk("presc0_delta", r2 - r1, 32'd12);

    // a held read is performed once
    access(8'h00, 1'b0, 2'd2, 32'h0, 5, r1);
    rd32(8'h00, r2);
    chk("held_read_once", r2 - r1, 32'd7);

    // low-word wrap and the high shadow
    wr32(8'h10, 32'd0);
    wr32(8'h00, 32'hFFFF_FFFE);
    wr32(8'h04, 32'd0);
    wr32(8'h10, 32'd1);
    rd32(8'h00, r1);
    rd32(8'h04, r2);
    chk("wrap_lo", r1, 32'hFFFF_FFFF);
    chk("wrap_hi_shadow", r2, 32'd0);
    rd32(8'h00, r1);
    rd32(8'h04, r3);
    chk("wrap_hi_after", r3, 32'd1);

    // compare interrupt
    wr32(8'h10, 32'd0);
    wr32(8'h00, 32'd0);
    wr32(8'h04, 32'd0);
    wr32(8'h08, 32'd100);
    wr32(8'h0C, 32'd0);
    chk("irq_idle", {31'b0, bus.irq}, 32'd0);
    wr32(8'h10, 32'd1);
    n = 0;
    while (!bus.irq && n < 300) begin
      step();
      n++;
    end
    chk("irq_rise_cycle", {31'b0, (n >= 98 && n <= 103)}, 32'd1);
    wr32(8'h0C, 32'd1);
    chk("irq_fall_cmp", {31'b0, bus.irq}, 32'd0);
    wr32(8'h0C, 32'd0);
    step();
    step();
    chk("irq_again", {31'b0, bus.irq}, 32'd1);
    wr32(8'h10, 32'd0);
    chk("irq_disable", {31'b0, bus.irq}, 32'd0);

    outside(32'h8000_2004, 5);
    outside(32'h0000_1000, 3);

    // reset while in ACK
    bus.address    = BASE + 32'h08;
    bus.rw         = 1'b1;
    bus.size       = 2'd2;
    bus.write_data = 32'h55;
    bus.rw_req     = 1'b1;
    step();
    reset = 1'b1;
    step();
    chk("reset_ack_dv", {31'b0, bus.data_valid}, 32'd0);
    reset      = 1'b0;
    bus.rw_req = 1'b0;
    step();
    rd32(8'h08, r1);
    chk("reset_cmp_lo", r1, 32'hFFFF_FFFF);

    for (int it = 0; it < 300; it++) begin
      logic [7:0]  off;
      logic [31:0] wd;
      logic [1:0]  sz;
      logic        rw;
      off = {3'b0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      if (off[4:2] == 3'd6) off = 8'hFC;
      wd = $urandom;
      if (off[4:2] == 3'd5) wd = wd & 32'h0007_0007;
      sz = 2'($urandom_range(0, 3));
      rw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0)
        outside(32'h9000_0000 | ($urandom & 32'hFF), 2);
      else
        access(off, rw, sz, wd, $urandom_range(0, 3), r1);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
